// File: rtl/multibank_pingpong_fifo_pkg.sv
// Shared types for the multi-bank ping-pong FIFO: write/read FSM state encodings.
package multibank_pingpong_fifo_pkg;

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } w_state_t;

  typedef enum logic {
    R_WAIT  = 1'b0,
    R_DRAIN = 1'b1
  } r_state_t;

endpackage

// File: rtl/multibank_pingpong_fifo_if.sv
// Write/read handshake and status bundle of the multi-bank ping-pong FIFO.
interface multibank_pingpong_fifo_if #(
  parameter int DATASIZE  = 8,
  parameter int NUM_BANKS = 2
);
  localparam int SEL_W = $clog2(NUM_BANKS);

  logic                 wen;
  logic [DATASIZE-1:0]  wdata;
  logic                 w_stop;
  logic [SEL_W-1:0]     wbank_sel;
  logic [NUM_BANKS-1:0] bank_full;
  logic                 rd_en;
  logic                 r_ready;
  logic [DATASIZE-1:0]  rdata;
  logic                 rvalid;
  logic [SEL_W-1:0]     rbank_sel;
  logic [NUM_BANKS-1:0] bank_empty;

  modport master (
    output wen, wdata, rd_en,
    input  w_stop, wbank_sel, bank_full, r_ready, rdata, rvalid, rbank_sel, bank_empty
  );

  modport slave (
    input  wen, wdata, rd_en,
    output w_stop, wbank_sel, bank_full, r_ready, rdata, rvalid, rbank_sel, bank_empty
  );
endinterface

// File: rtl/multibank_pingpong_fifo_bank.sv
// One bank: DEPTH-word dual-clock RAM, binary/gray pointers, gray crossings and
// full/empty flags seen from both the write and the read domain.
module multibank_pingpong_fifo_bank #(
  parameter int DATASIZE    = 8,
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                we,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  output logic [DATASIZE-1:0] rdata,
  output logic                full_w,
  output logic                empty_w,
  output logic                full_r,
  output logic                empty_r
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0] wbin, wgray, wbin_nxt, rbin, rgray, rbin_nxt;
  logic [SYNC_STAGES-1:0][ADDRSIZE:0] wgray_r, rgray_w;
  logic [ADDRSIZE:0] wgray_s, rgray_s;
  logic wr_ok, rd_ok;

  assign wgray_s  = wgray_r[SYNC_STAGES-1];
  assign rgray_s  = rgray_w[SYNC_STAGES-1];
  assign wbin_nxt = wbin + (ADDRSIZE+1)'(1);
  assign rbin_nxt = rbin + (ADDRSIZE+1)'(1);

  // Full: pointers one lap apart, which in gray code means the two MSBs differ.
  assign full_w  = (wgray == {~rgray_s[ADDRSIZE -: 2], rgray_s[ADDRSIZE-2:0]});
  assign empty_w = (wgray == rgray_s);
  assign full_r  = (rgray == {~wgray_s[ADDRSIZE -: 2], wgray_s[ADDRSIZE-2:0]});
  assign empty_r = (rgray == wgray_s);

  assign wr_ok = we && !full_w;
  assign rd_ok = re && !empty_r;

  // NOTE: the RAM has no reset; clearing the pointers is enough to discard its contents.
  always_ff @(posedge wclk)
    if (wr_ok) mem[wbin[ADDRSIZE-1:0]] <= wdata;

  assign rdata = mem[rbin[ADDRSIZE-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wgray <= '0;
    end else if (wr_ok) begin
      wbin  <= wbin_nxt;
      wgray <= wbin_nxt ^ (wbin_nxt >> 1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin  <= '0;
      rgray <= '0;
    end else if (rd_ok) begin
      rbin  <= rbin_nxt;
      rgray <= rbin_nxt ^ (rbin_nxt >> 1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) wgray_r <= '0;
    else         wgray_r <= {wgray_r[SYNC_STAGES-2:0], wgray};

  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) rgray_w <= '0;
    else         rgray_w <= {rgray_w[SYNC_STAGES-2:0], rgray};
endmodule

// File: rtl/multibank_pingpong_fifo.sv
// N-bank block-exclusive ping-pong FIFO, wclk -> rclk; whole blocks only, round-robin banks.
// Define MBFIFO_OREG_EN to add a registered output stage (rdata/rvalid 2 rclk after rd_en).
module multibank_pingpong_fifo
  import multibank_pingpong_fifo_pkg::*;
#(
  parameter int DATASIZE    = 8,
  parameter int ADDRSIZE    = 4,
  parameter int NUM_BANKS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic                      wclk,
  input logic                      rst_n,
  input logic                      rclk,
  multibank_pingpong_fifo_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_BANKS);
  localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_BANKS - 1);

  logic [1:0] wrst_q, rrst_q;
  logic       wrst_n, rrst_n;

  // Reset asserts immediately and releases synchronously in each domain.
  always_ff @(posedge wclk or negedge rst_n)
    if (!rst_n) wrst_q <= '0;
    else        wrst_q <= {wrst_q[0], 1'b1};

  always_ff @(posedge rclk or negedge rst_n)
    if (!rst_n) rrst_q <= '0;
    else        rrst_q <= {rrst_q[0], 1'b1};

  assign wrst_n = wrst_q[1];
  assign rrst_n = rrst_q[1];

  w_state_t             w_state;
  r_state_t             r_state;
  logic [ADDRSIZE-1:0]  wcnt, rcnt;
  logic [SEL_W-1:0]     wbank_sel, rbank_sel;
  logic                 w_stop, r_ready, wr_fire, rd_fire;
  logic [NUM_BANKS-1:0] full_w, empty_w, full_r, empty_r;
  logic [DATASIZE-1:0]  bank_rdata [NUM_BANKS];
  logic [DATASIZE-1:0]  rd_word, rdata_q;
  logic                 rvalid_q;

  assign wr_fire = bus.wen && (w_state == W_FILL);
  assign rd_fire = bus.rd_en && r_ready;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      w_state   <= W_FILL;
      wcnt      <= '0;
      wbank_sel <= '0;
      w_stop    <= 1'b0;
    end else begin
      case (w_state)
        W_FILL: if (bus.wen) begin
          wcnt <= wcnt + ADDRSIZE'(1);
          if (&wcnt) begin
            wbank_sel <= (wbank_sel == LAST_BANK) ? '0 : wbank_sel + SEL_W'(1);
            w_state   <= W_WAIT;
            w_stop    <= 1'b1;
          end
        end
        W_WAIT: if (empty_w[wbank_sel]) begin
          w_state <= W_FILL;
          w_stop  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state   <= R_WAIT;
      rcnt      <= '0;
      rbank_sel <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        R_WAIT: if (full_r[rbank_sel]) begin
          r_state <= R_DRAIN;
          r_ready <= 1'b1;
        end
        R_DRAIN: if (bus.rd_en) begin
          rcnt <= rcnt + ADDRSIZE'(1);
          if (&rcnt) begin
            rbank_sel <= (rbank_sel == LAST_BANK) ? '0 : rbank_sel + SEL_W'(1);
            r_state   <= R_WAIT;
            r_ready   <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    multibank_pingpong_fifo_bank #(
      .DATASIZE   (DATASIZE),
      .ADDRSIZE   (ADDRSIZE),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_bank (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .we     (wr_fire && (wbank_sel == SEL_W'(b))),
      .wdata  (bus.wdata),
      .re     (rd_fire && (rbank_sel == SEL_W'(b))),
      .rdata  (bank_rdata[b]),
      .full_w (full_w[b]),
      .empty_w(empty_w[b]),
      .full_r (full_r[b]),
      .empty_r(empty_r[b])
    );
  end

  // NOTE: a default before the loop keeps this purely combinational (no latch).
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (rbank_sel == SEL_W'(b)) rd_word = bank_rdata[b];
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) rdata_q <= rd_word;
    end
  end

`ifdef MBFIFO_OREG_EN
  logic [DATASIZE-1:0] rdata_o;
  logic                rvalid_o;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= rvalid_q;
      rdata_o  <= rdata_q;
    end
  end

  assign bus.rdata  = rdata_o;
  assign bus.rvalid = rvalid_o;
`else
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.w_stop     = w_stop;
  assign bus.wbank_sel  = wbank_sel;
  assign bus.bank_full  = full_w;
  assign bus.r_ready    = r_ready;
  assign bus.rbank_sel  = rbank_sel;
  assign bus.bank_empty = empty_r;
endmodule

// File: tb/tb_multibank_pingpong_fifo.sv
// Directed bench for multibank_pingpong_fifo: 3 banks of 16 bytes, wclk 20 ns, rclk 40 ns.
module tb_multibank_pingpong_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NB = 3;
`ifdef MBFIFO_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic wclk  = 1'b0;
  logic rclk  = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass   = 0;
  int   n_checks = 0;
  time  t_wfall  = 0;

  multibank_pingpong_fifo_if #(.DATASIZE(DW), .NUM_BANKS(NB)) bus ();

  multibank_pingpong_fifo #(
    .DATASIZE(DW), .ADDRSIZE(AW), .NUM_BANKS(NB), .SYNC_STAGES(2)
  ) dut (
    .wclk (wclk),
    .rst_n(rst_n),
    .rclk (rclk),
    .bus  (bus)
  );

  // Offset rclk so its edges never coincide with wclk edges.
  initial forever #10 wclk = ~wclk;
  initial begin
    #5;
    forever #20 rclk = ~rclk;
  end

  always @(negedge bus.w_stop) t_wfall = $time;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_w_stop"},     32'(bus.w_stop),     32'd0);
    check({pfx, "_wbank_sel"},  32'(bus.wbank_sel),  32'd0);
    check({pfx, "_rbank_sel"},  32'(bus.rbank_sel),  32'd0);
    check({pfx, "_bank_full"},  32'(bus.bank_full),  32'd0);
    check({pfx, "_bank_empty"}, 32'(bus.bank_empty), 32'h7);
    check({pfx, "_r_ready"},    32'(bus.r_ready),    32'd0);
    check({pfx, "_rvalid"},     32'(bus.rvalid),     32'd0);
    check({pfx, "_rdata"},      32'(bus.rdata),      32'd0);
  endtask

  // Call at a wclk falling edge; returns at the falling edge after the write.
  task automatic write_word(input logic [DW-1:0] d);
    int guard = 0;
    while (bus.w_stop !== 1'b0 && guard < 400) begin
      @(negedge wclk);
      guard++;
    end
    if (guard >= 400) check("write_stall_timeout", 32'(bus.w_stop), 32'd0);
    bus.wen   = 1'b1;
    bus.wdata = d;
    @(negedge wclk);
    bus.wen   = 1'b0;
  endtask

  initial begin
    int  nread, first_cyc, wctr, rexp, nrd, nvalid, nready;
    time t_read16;
    bus.wen   = 1'b0;
    bus.wdata = '0;
    bus.rd_en = 1'b0;

    // 1: reset values
    #2 rst_n = 1'b0;
    #30;
    check_reset("t1");
    @(negedge wclk);
    rst_n = 1'b1;
    repeat (6) @(negedge rclk);
    check("t1_empty_after_release", 32'(bus.bank_empty), 32'h7);
    check("t1_ready_after_release", 32'(bus.r_ready), 32'd0);

    // 2: fill all three banks, reader idle, then a dropped 49th write
    @(negedge wclk);
    for (int i = 0; i < 48; i++) begin
      write_word(DW'(i));
      if (i == 15) check("t2_wsel_after_blk0", 32'(bus.wbank_sel), 32'd1);
      if (i == 31) check("t2_wsel_after_blk1", 32'(bus.wbank_sel), 32'd2);
    end
    check("t2_w_stop", 32'(bus.w_stop), 32'd1);
    check("t2_wbank_sel", 32'(bus.wbank_sel), 32'd0);
    check("t2_bank_full", 32'(bus.bank_full), 32'h7);
    bus.wen   = 1'b1;
    bus.wdata = 8'd48;
    @(negedge wclk);
    bus.wen   = 1'b0;
    check("t2_drop_w_stop", 32'(bus.w_stop), 32'd1);
    repeat (6) @(negedge rclk);
    check("t2_bank_empty_rview", 32'(bus.bank_empty), 32'd0);
    check("t2_r_ready", 32'(bus.r_ready), 32'd1);
    check("t2_rbank_sel", 32'(bus.rbank_sel), 32'd0);

    // 3: drain everything with rd_en held high
    t_wfall   = 0;
    t_read16  = 0;
    nread     = 0;
    first_cyc = 0;
    @(negedge rclk);
    bus.rd_en = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge rclk);
      if (bus.rvalid === 1'b1) begin
        if (nread == 0) first_cyc = c;
        if (nread < 48) check($sformatf("t3_rdata_%0d", nread), 32'(bus.rdata), 32'(nread));
        nread++;
        if (nread == 16) t_read16 = $time - 20 - (RD_LAT - 1) * 40;
        if (nread % 16 == 0 && nread <= 48)
          check($sformatf("t3_rsel_after_%0d", nread), 32'(bus.rbank_sel), 32'((nread / 16) % 3));
      end
    end
    check("t3_nread", 32'(nread), 32'd48);
    check("t3_first_latency", 32'(first_cyc), 32'(RD_LAT));
    check("t3_wstop_fall_window", 32'((t_wfall > t_read16) && (t_wfall - t_read16 <= 80)), 32'd1);
    check("t3_w_stop_low", 32'(bus.w_stop), 32'd0);

    // 4: free-running counter writer against a continuous reader
    wctr = 0;
    rexp = 0;
    nrd  = 0;
    fork
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge wclk);
          if (bus.w_stop === 1'b0) begin
            bus.wen   = 1'b1;
            bus.wdata = DW'(wctr);
            wctr++;
          end else begin
            bus.wen = 1'b0;
          end
        end
        @(negedge wclk);
        bus.wen = 1'b0;
      end
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge rclk);
          if (bus.rvalid === 1'b1) begin
            check($sformatf("t4_rdata_%0d", nrd), 32'(bus.rdata), 32'(DW'(rexp)));
            rexp++;
            nrd++;
          end
        end
      end
    join
    check("t4_whole_blocks_only", 32'(nrd), 32'((wctr / 16) * 16));

    // 5: partial block never readable; reset mid-operation discards it
    @(negedge wclk);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge wclk);
    rst_n = 1'b1;
    repeat (6) @(negedge rclk);
    @(negedge wclk);
    for (int i = 0; i < 10; i++) write_word(DW'(8'hA0 + i));
    nvalid = 0;
    nready = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      if (bus.rvalid === 1'b1) nvalid++;
      if (bus.r_ready === 1'b1) nready++;
    end
    check("t5_partial_no_rvalid", 32'(nvalid), 32'd0);
    check("t5_partial_no_ready", 32'(nready), 32'd0);
    check("t5_partial_bank_empty", 32'(bus.bank_empty), 32'h6);
    @(negedge wclk);
    #3 rst_n = 1'b0;
    #1;
    check_reset("t5_mid");
    #5;
    @(negedge wclk);
    rst_n = 1'b1;
    repeat (6) @(negedge rclk);
    @(negedge wclk);
    for (int i = 0; i < 16; i++) write_word(DW'(i));
    nrd = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge rclk);
      if (bus.rvalid === 1'b1) begin
        check(nrd == 0 ? "t5_first_rdata" : $sformatf("t5_rdata_%0d", nrd), 32'(bus.rdata), 32'(nrd));
        nrd++;
      end
    end
    check("t5_nread", 32'(nrd), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
